// File: rtl/writeback_pkg.sv
// writeback_pkg: shared definitions for the writeback stage.
//   - wselector bit positions (PC redirect, register write, float bank)
//   - register index constants
//   - stage state enum and the commit request record
//   - next_pc helper
package writeback_pkg;

   localparam int unsigned WSEL_PC  = 2;
   localparam int unsigned WSEL_REG = 1;
   localparam int unsigned WSEL_FLT = 0;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_SP   = 5'd29;
   localparam logic [4:0] REG_RA   = 5'd31;

   typedef enum logic {
      StInit,
      StRun
   } wb_state_e;

   typedef struct packed {
      logic [2:0]  wsel;
      logic [31:0] data;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] pc_target;
   } wb_req_t;

   // Redirect targets are forced word-aligned; the sequential path wraps mod 2^32.
   function automatic logic [31:0] next_pc(input wb_req_t req);
      if (req.wsel[WSEL_PC]) begin
         return {req.pc_target[31:2], 2'b00};
      end
      return req.pc + 32'd4;
   endfunction

endpackage

// File: rtl/writeback_regbank.sv
// regbank: 32 x 32-bit register bank.
//   clk              core clock
//   we/waddr/wdata   synchronous write port; writes to index 0 are dropped
//   raddr_a/rdata_a  asynchronous read port A (index 0 reads zero)
//   raddr_b/rdata_b  asynchronous read port B (index 0 reads zero)
// No reset: the writeback init sweep clears every entry after reset.
module regbank
   import writeback_pkg::*;
(
   input  logic        clk,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr_a,
   output logic [31:0] rdata_a,
   input  logic [4:0]  raddr_b,
   output logic [31:0] rdata_b
);

   logic [31:0] mem [32];

   always_ff @(posedge clk) begin
      if (we && (waddr != REG_ZERO)) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == REG_ZERO) ? 32'h0 : mem[raddr_a];
   assign rdata_b = (raddr_b == REG_ZERO) ? 32'h0 : mem[raddr_b];

endmodule

// File: rtl/writeback.sv
// writeback: final pipeline stage. Commits execute results to the integer or
// float bank, computes the next PC and pulses done. Owns both register banks
// and serves the decode stage's two combinational read ports.
//   clk, rstn                       clock, async active-low reset
//   enable                          execute result valid (one-cycle strobe)
//   wselector[2:0]                  {redirect, reg write, float bank}
//   data, rd, pc, pc_target         commit payload
//   rs_no/fmode1, rt_no/fmode2      read indices and bank selects
//   rs_data, rt_data                combinational read data
//   pc_next                         PC for fetch
//   done                            one-cycle commit acknowledge
//   ready                           high once the init sweep has finished
// Optional feature: define WB_BYPASS_EN to forward a same-cycle register write
// to a matching read port.
module writeback
   import writeback_pkg::*;
#(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter logic [31:0] SP_INIT = 32'h003f_fffc
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        enable,
   input  logic [2:0]  wselector,
   input  logic [31:0] data,
   input  logic [4:0]  rd,
   input  logic [31:0] pc,
   input  logic [31:0] pc_target,
   input  logic [4:0]  rs_no,
   input  logic [4:0]  rt_no,
   input  logic        fmode1,
   input  logic        fmode2,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data,
   output logic [31:0] pc_next,
   output logic        done,
   output logic        ready
);

   wb_state_e   state_q, state_d;
   logic [4:0]  init_idx_q, init_idx_d;
   logic        ready_q, ready_d;
   logic        done_q;
   logic [31:0] pc_next_q;
   logic        pend_q, pend_d;
   wb_req_t     pend_req_q, pend_req_d;

   wb_req_t     in_req;
   wb_req_t     cm_req;
   logic        cm_valid;
   logic        cm_reg_wr;

   logic        int_we, flt_we;
   logic [4:0]  int_waddr, flt_waddr;
   logic [31:0] int_wdata, flt_wdata;
   logic [31:0] int_rs, int_rt, flt_rs, flt_rt;

   assign in_req = '{wsel: wselector, data: data, rd: rd, pc: pc, pc_target: pc_target};

   // Next state and commit selection. A pending request captured during INIT
   // commits first; an enable arriving in that same cycle takes its place in
   // the pending slot so it is not lost.
   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      ready_d    = ready_q;
      pend_d     = pend_q;
      pend_req_d = pend_req_q;
      cm_valid   = 1'b0;
      cm_req     = in_req;
      unique case (state_q)
         StInit: begin
            init_idx_d = init_idx_q + 5'd1;
            if (init_idx_q == REG_RA) begin
               state_d = StRun;
               ready_d = 1'b1;
            end
            if (enable) begin
               pend_d     = 1'b1;
               pend_req_d = in_req;
            end
         end
         StRun: begin
            if (pend_q) begin
               cm_valid = 1'b1;
               cm_req   = pend_req_q;
               pend_d   = enable;
               if (enable) begin
                  pend_req_d = in_req;
               end
            end else if (enable) begin
               cm_valid = 1'b1;
            end
         end
         default: begin
            state_d = StInit;
         end
      endcase
   end

   assign cm_reg_wr = cm_valid && cm_req.wsel[WSEL_REG] && (cm_req.rd != REG_ZERO);

   // Bank write ports: the init sweep owns both banks until RUN.
   always_comb begin
      if (state_q == StInit) begin
         int_we    = 1'b1;
         flt_we    = 1'b1;
         int_waddr = init_idx_q;
         flt_waddr = init_idx_q;
         int_wdata = (init_idx_q == REG_SP) ? SP_INIT : 32'h0;
         flt_wdata = 32'h0;
      end else begin
         int_we    = cm_reg_wr && !cm_req.wsel[WSEL_FLT];
         flt_we    = cm_reg_wr && cm_req.wsel[WSEL_FLT];
         int_waddr = cm_req.rd;
         flt_waddr = cm_req.rd;
         int_wdata = cm_req.data;
         flt_wdata = cm_req.data;
      end
   end

   regbank u_int_bank (
      .clk     (clk),
      .we      (int_we),
      .waddr   (int_waddr),
      .wdata   (int_wdata),
      .raddr_a (rs_no),
      .rdata_a (int_rs),
      .raddr_b (rt_no),
      .rdata_b (int_rt)
   );

   regbank u_flt_bank (
      .clk     (clk),
      .we      (flt_we),
      .waddr   (flt_waddr),
      .wdata   (flt_wdata),
      .raddr_a (rs_no),
      .rdata_a (flt_rs),
      .raddr_b (rt_no),
      .rdata_b (flt_rt)
   );

   always_comb begin
      rs_data = fmode1 ? flt_rs : int_rs;
      rt_data = fmode2 ? flt_rt : int_rt;
`ifdef WB_BYPASS_EN
      if (cm_reg_wr && (cm_req.wsel[WSEL_FLT] == fmode1) && (cm_req.rd == rs_no)) begin
         rs_data = cm_req.data;
      end
      if (cm_reg_wr && (cm_req.wsel[WSEL_FLT] == fmode2) && (cm_req.rd == rt_no)) begin
         rt_data = cm_req.data;
      end
`endif
      // Banks are mid-sweep during INIT, so their contents are not yet valid.
      if (state_q == StInit) begin
         rs_data = 32'h0;
         rt_data = 32'h0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StInit;
         init_idx_q <= 5'd0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
         pc_next_q  <= PC_INIT;
         pend_q     <= 1'b0;
         pend_req_q <= '0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
         ready_q    <= ready_d;
         done_q     <= cm_valid;
         pend_q     <= pend_d;
         pend_req_q <= pend_req_d;
         if (cm_valid) begin
            pc_next_q <= next_pc(cm_req);
         end
      end
   end

   assign pc_next = pc_next_q;
   assign done    = done_q;
   assign ready   = ready_q;

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;

   localparam logic [31:0] PC_INIT = 32'h0000_0000;
   localparam logic [31:0] SP_INIT = 32'h003f_fffc;

   logic        clk = 1'b0;
   logic        rstn;
   logic        enable;
   logic [2:0]  wselector;
   logic [31:0] data;
   logic [4:0]  rd;
   logic [31:0] pc;
   logic [31:0] pc_target;
   logic [4:0]  rs_no, rt_no;
   logic        fmode1, fmode2;
   logic [31:0] rs_data, rt_data;
   logic [31:0] pc_next;
   logic        done;
   logic        ready;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_q[$];
   logic [31:0] int_m[32];
   logic [31:0] flt_m[32];

   writeback #(
      .PC_INIT (PC_INIT),
      .SP_INIT (SP_INIT)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .enable    (enable),
      .wselector (wselector),
      .data      (data),
      .rd        (rd),
      .pc        (pc),
      .pc_target (pc_target),
      .rs_no     (rs_no),
      .rt_no     (rt_no),
      .fmode1    (fmode1),
      .fmode2    (fmode2),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
      .pc_next   (pc_next),
      .done      (done),
      .ready     (ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [4:0] idx, input logic fm);
      if (idx == 5'd0) return 32'h0;
      return fm ? flt_m[idx] : int_m[idx];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         int_m[i] = 32'h0;
         flt_m[i] = 32'h0;
      end
      int_m[29] = SP_INIT;
   endtask

   // Scoreboard: every done pulse pops one expected pc_next.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("done_unexpected", {31'b0, done}, 32'h0);
         end else begin
            check("pc_next", pc_next, exp_q.pop_front());
         end
      end
   end

   // Called just after a posedge; returns just after the commit edge.
   task automatic commit(input logic [2:0] ws, input logic [4:0] r, input logic [31:0] d,
                         input logic [31:0] p, input logic [31:0] t);
      wselector = ws; rd = r; data = d; pc = p; pc_target = t; enable = 1'b1;
      exp_q.push_back(ws[2] ? {t[31:2], 2'b00} : p + 32'd4);
      @(posedge clk); #1;
      enable = 1'b0;
      if (ws[1] && r != 5'd0) begin
         if (ws[0]) flt_m[r] = d;
         else       int_m[r] = d;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check("drain", exp_q.size(), 32'd0);
      @(negedge clk);
      check("done_low", {31'b0, done}, 32'h0);
      @(posedge clk); #1;
   endtask

   task automatic read_chk(input string tag, input logic [4:0] idx, input logic fm);
      rs_no = idx; fmode1 = fm; rt_no = idx; fmode2 = fm;
      #1;
      check({tag, "_rs"}, rs_data, model_rd(idx, fm));
      check({tag, "_rt"}, rt_data, model_rd(idx, fm));
   endtask

   initial begin
      rstn = 1'b0; enable = 1'b0; wselector = 3'b0; data = 32'h0; rd = 5'd0;
      pc = 32'h0; pc_target = 32'h0; rs_no = 5'd0; rt_no = 5'd0;
      fmode1 = 1'b0; fmode2 = 1'b0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'b0, ready}, 32'h0);
      check("rst_done", {31'b0, done}, 32'h0);
      check("rst_pc_next", pc_next, PC_INIT);

      // Init sweep: ready low for 31 edges, high on the 32nd. A request issued
      // during INIT is held and commits in the first RUN cycle.
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 1; i <= 31; i++) begin
         @(posedge clk); #1;
         if (i == 20) begin
            wselector = 3'b010; rd = 5'd3; data = 32'h55; pc = 32'h40; enable = 1'b1;
            exp_q.push_back(32'h44);
         end
         if (i == 21) enable = 1'b0;
         if (i == 31) begin
            rs_no = 5'd29; fmode1 = 1'b0;
            #1;
            check("init_read_zero", rs_data, 32'h0);
         end
         check("init_ready_low", {31'b0, ready}, 32'h0);
      end
      @(posedge clk); #1;
      check("ready_high", {31'b0, ready}, 32'h1);
      int_m[3] = 32'h55;
      drain();

      for (int i = 0; i < 32; i++) begin
         read_chk("sweep_int", 5'(i), 1'b0);
         read_chk("sweep_flt", 5'(i), 1'b1);
      end

      commit(3'b010, 5'd5, 32'h1234, 32'h100, 32'h0);
      drain();
      read_chk("int_r5", 5'd5, 1'b0);

      commit(3'b011, 5'd0, 32'h3f80_0000, 32'h104, 32'h0);
      drain();
      read_chk("flt_f0", 5'd0, 1'b1);

      commit(3'b110, 5'd31, 32'h208, 32'h108, 32'h403);
      drain();
      read_chk("int_r31", 5'd31, 1'b0);

      commit(3'b000, 5'd4, 32'hbad, 32'hffff_fffc, 32'h0);
      drain();
      read_chk("store_r4", 5'd4, 1'b0);

      commit(3'b011, 5'd2, 32'h3f80_0000, 32'h10, 32'h0);
      drain();
      read_chk("flt_f2", 5'd2, 1'b1);
      read_chk("int_r2", 5'd2, 1'b0);

      commit(3'b010, 5'd10, 32'haaaa, 32'h20, 32'h0);
      commit(3'b010, 5'd11, 32'hbbbb, 32'h24, 32'h0);
      drain();
      read_chk("b2b_r10", 5'd10, 1'b0);
      read_chk("b2b_r11", 5'd11, 1'b0);

      // Same-cycle read of a register being written.
      commit(3'b010, 5'd7, 32'h77, 32'h30, 32'h0);
      drain();
      rs_no = 5'd7; fmode1 = 1'b0;
      wselector = 3'b010; rd = 5'd7; data = 32'hdead; pc = 32'h200; enable = 1'b1;
      exp_q.push_back(32'h204);
      #2;
`ifdef WB_BYPASS_EN
      check("bypass_same_cycle", rs_data, 32'hdead);
`else
      check("no_bypass_same_cycle", rs_data, 32'h77);
`endif
      @(posedge clk); #1;
      enable = 1'b0;
      int_m[7] = 32'hdead;
      check("write_next_cycle", rs_data, 32'hdead);
      drain();

      // Reset landing on a commit: the write is lost and INIT restarts.
      wselector = 3'b010; rd = 5'd9; data = 32'habc; pc = 32'h300; enable = 1'b1;
      #2;
      rstn = 1'b0;
      @(posedge clk); #1;
      enable = 1'b0;
      check("midrst_pc_next", pc_next, PC_INIT);
      check("midrst_done", {31'b0, done}, 32'h0);
      check("midrst_ready", {31'b0, ready}, 32'h0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 40 && ready !== 1'b1; i++) @(posedge clk);
      #1;
      check("reinit_ready", {31'b0, ready}, 32'h1);
      read_chk("reinit_r9", 5'd9, 1'b0);
      read_chk("reinit_r5", 5'd5, 1'b0);
      read_chk("reinit_sp", 5'd29, 1'b0);
      read_chk("reinit_f2", 5'd2, 1'b1);
      check("reinit_queue", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
